// File: rtl/game_mm_pkg.sv
// game_mm_pkg: shared constants for the game_mm_regs register bank.
// Holds word addresses, the ID constant, CTRL/STATUS bit positions, the
// TICK_DIV reset value and a byte-enable merge helper.
package game_mm_pkg;

    localparam logic [4:0] AddrId      = 5'h00;
    localparam logic [4:0] AddrCtrl    = 5'h01;
    localparam logic [4:0] AddrStatus  = 5'h02;
    localparam logic [4:0] AddrEvent   = 5'h03;
    localparam logic [4:0] AddrTickDiv = 5'h04;
    localparam logic [4:0] AddrTickCnt = 5'h05;
    localparam logic [4:0] AddrOvfClr  = 5'h06;

    localparam logic [31:0] IdValue    = 32'h4741_4D45;
    localparam logic [31:0] TickDivRst = 32'h0000_C34F;

    localparam int unsigned CtrlTickEn  = 0;
    localparam int unsigned CtrlIrqEn   = 1;
    localparam int unsigned CtrlFifoClr = 2;

    localparam int unsigned StatEmpty  = 8;
    localparam int unsigned StatFull   = 9;
    localparam int unsigned StatOvf    = 10;
    localparam int unsigned StatCntLsb = 16;

    // Merge a write into an existing word, one byte lane per enable bit.
    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old_val[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/game_evt_fifo.sv
// game_evt_fifo: synchronous FIFO for button press events.
// Ports: clk, reset (sync, active-high), clear (empties the FIFO, beats push/pop),
// push/wdata, pop/rdata (show-ahead), full, empty, count.
// A push while full is dropped unless a pop happens in the same cycle.
module game_evt_fifo
    import game_mm_pkg::*;
#(
    parameter int unsigned Width = 21,
    parameter int unsigned Depth = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [Width-1:0]         wdata,
    input  logic                     pop,
    output logic [Width-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] PtrOne = 1;

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [Width-1:0] mem [Depth];
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | pop);
    assign rdata   = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

    // When full with push+pop, the write slot equals the read slot; the
    // popped word is sampled from the old contents at the same edge.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/game_mm_regs.sv
// game_mm_regs: Avalon-MM slave register bank for the game fabric.
// Ports: clk_clk, reset_reset (sync, active-high); s_mmo_* Avalon-MM slave with
// fixed read latency 1; btn_in raw async buttons; irq level interrupt.
// Debounces buttons, queues press masks with a tick timestamp, runs the tick
// counter and holds scratch registers.
module game_mm_regs
    import game_mm_pkg::*;
#(
    parameter int unsigned BTN_W           = 5,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              s_mmo_write,
    input  logic              s_mmo_read,
    input  logic [4:0]        s_mmo_address,
    input  logic [31:0]       s_mmo_writedata,
    input  logic [3:0]        s_mmo_byteenable,
    output logic [31:0]       s_mmo_readdata,
    input  logic [BTN_W-1:0]  btn_in,
    output logic              irq
);

    localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned EvtW = BTN_W + 16;
    localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DbW-1:0] DbOne  = 1;

    logic [BTN_W-1:0] sync1_q, sync2_q, db_level_q, db_level_d, db_prev_q;
    logic [DbW-1:0]   db_cnt_q [BTN_W];
    logic [DbW-1:0]   db_cnt_d [BTN_W];
    logic             tick_en_q, irq_en_q, ovf_q, irq_q;
    logic [31:0]      tick_div_q, presc_q, tick_cnt_q, readdata_q, rd_mux;
    logic [31:0]      status_word, event_word;
    logic [31:0]      scratch_q [8];

    logic [BTN_W-1:0] press_mask;
    logic             push, pop, fifo_clear, ovf_set, ovf_clr;
    logic             wr_ctrl, wr_tick_div, wr_scratch;
    logic [EvtW-1:0]  fifo_rdata;
    logic             fifo_full, fifo_empty;
    logic [CntW-1:0]  fifo_count;

    // Debounced level follows the synchronized input only after it has
    // disagreed for DEBOUNCE_CYCLES consecutive clocks.
    always_comb begin
        db_level_d = db_level_q;
        for (int i = 0; i < BTN_W; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_level_q[i]) begin
                if (db_cnt_q[i] == DbLast) db_level_d[i] = sync2_q[i];
                else                       db_cnt_d[i] = db_cnt_q[i] + DbOne;
            end
        end
    end

    assign press_mask  = db_level_q & ~db_prev_q;
    assign push        = |press_mask;
    assign pop         = s_mmo_read && (s_mmo_address == AddrEvent) && !fifo_empty;
    assign wr_ctrl     = s_mmo_write && (s_mmo_address == AddrCtrl);
    assign wr_tick_div = s_mmo_write && (s_mmo_address == AddrTickDiv);
    assign wr_scratch  = s_mmo_write && (s_mmo_address[4:3] == 2'b01);
    assign fifo_clear  = wr_ctrl && s_mmo_byteenable[0] && s_mmo_writedata[CtrlFifoClr];
    assign ovf_clr     = s_mmo_write && (s_mmo_address == AddrOvfClr) &&
                         s_mmo_byteenable[0] && s_mmo_writedata[0];
    assign ovf_set     = push && fifo_full && !pop && !fifo_clear;

    game_evt_fifo #(
        .Width (EvtW),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_clk),
        .reset (reset_reset),
        .clear (fifo_clear),
        .push  (push),
        .wdata ({tick_cnt_q[15:0], press_mask}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status_word                    = '0;
        status_word[BTN_W-1:0]         = db_level_q;
        status_word[StatEmpty]         = fifo_empty;
        status_word[StatFull]          = fifo_full;
        status_word[StatOvf]           = ovf_q;
        status_word[StatCntLsb +: 8]   = 8'(fifo_count);
        event_word                     = '0;
        event_word[31:16]              = fifo_rdata[BTN_W +: 16];
        event_word[BTN_W-1:0]          = fifo_rdata[BTN_W-1:0];
    end

    always_comb begin
        rd_mux = '0;
        case (s_mmo_address)
            AddrId:      rd_mux = IdValue;
            AddrCtrl: begin
                rd_mux[CtrlTickEn] = tick_en_q;
                rd_mux[CtrlIrqEn]  = irq_en_q;
            end
            AddrStatus:  rd_mux = status_word;
            AddrEvent:   if (!fifo_empty) rd_mux = event_word;
            AddrTickDiv: rd_mux = tick_div_q;
            AddrTickCnt: rd_mux = tick_cnt_q;
            default:     if (s_mmo_address[4:3] == 2'b01) rd_mux = scratch_q[s_mmo_address[2:0]];
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_level_q <= '0;
            db_prev_q  <= '0;
            for (int i = 0; i < BTN_W; i++) db_cnt_q[i] <= '0;
            tick_en_q  <= 1'b0;
            irq_en_q   <= 1'b0;
            tick_div_q <= TickDivRst;
            presc_q    <= '0;
            tick_cnt_q <= '0;
            ovf_q      <= 1'b0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
            for (int i = 0; i < 8; i++) scratch_q[i] <= '0;
        end else begin
            sync1_q    <= btn_in;
            sync2_q    <= sync1_q;
            db_level_q <= db_level_d;
            db_prev_q  <= db_level_q;
            for (int i = 0; i < BTN_W; i++) db_cnt_q[i] <= db_cnt_d[i];

            if (wr_ctrl && s_mmo_byteenable[0]) begin
                tick_en_q <= s_mmo_writedata[CtrlTickEn];
                irq_en_q  <= s_mmo_writedata[CtrlIrqEn];
            end

            if (wr_tick_div) begin
                tick_div_q <= apply_be(tick_div_q, s_mmo_writedata, s_mmo_byteenable);
                presc_q    <= '0;
            end else if (tick_en_q) begin
                if (presc_q == tick_div_q) begin
                    presc_q    <= '0;
                    tick_cnt_q <= tick_cnt_q + 32'd1;
                end else begin
                    presc_q    <= presc_q + 32'd1;
                end
            end

            // A dropped event outranks a same-cycle clear request.
            if (ovf_set)      ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;

            if (wr_scratch) begin
                scratch_q[s_mmo_address[2:0]] <= apply_be(scratch_q[s_mmo_address[2:0]],
                                                          s_mmo_writedata, s_mmo_byteenable);
            end

            if (s_mmo_read) readdata_q <= rd_mux;
            irq_q <= irq_en_q & ~fifo_empty;
        end
    end

    assign s_mmo_readdata = readdata_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_game_mm_regs.sv
// tb_game_mm_regs: directed self-checking bench for game_mm_regs.
// Small debounce window and a 4-deep FIFO keep press scenarios short.
module tb_game_mm_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic [31:0] rdata;
    logic [4:0]  btn = '0;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    game_mm_regs #(
        .BTN_W           (5),
        .FIFO_DEPTH      (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk_clk          (clk),
        .reset_reset      (reset),
        .s_mmo_write      (wr),
        .s_mmo_read       (rd),
        .s_mmo_address    (addr),
        .s_mmo_writedata  (wdata),
        .s_mmo_byteenable (be),
        .s_mmo_readdata   (rdata),
        .btn_in           (btn),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    // All tasks start and end at a falling edge; the rising edge in between
    // is the bus cycle.
    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; be = b; wr = 1'b1;
        @(negedge clk);
        wr = 1'b0; be = '0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        addr = a; rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic press(input int b, input int hold);
        btn[b] = 1'b1;
        repeat (hold) @(negedge clk);
        btn[b] = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_readdata: got %h want %h", rdata, 32'h0); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
        bus_read(5'h00, d);
        n_cmp++; if (d !== 32'h4741_4D45) begin n_bad++; $display("FAIL id: got %h want %h", d, 32'h4741_4D45); end
        bus_read(5'h01, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL ctrl_reset: got %h want %h", d, 32'h0); end
        bus_read(5'h04, d);
        n_cmp++; if (d !== 32'h0000_C34F) begin n_bad++; $display("FAIL tickdiv_reset: got %h want %h", d, 32'h0000_C34F); end
        bus_read(5'h02, d);
        n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL status_reset: got %h want %h", d, 32'h100); end
    endtask

    task automatic test_scratch;
        logic [31:0] d;
        bus_write(5'h08, 32'hFFFF_FFFF, 4'hF);
        bus_write(5'h08, 32'h1234_5678, 4'b0101);
        bus_read(5'h08, d);
        n_cmp++; if (d !== 32'hFF34_FF78) begin n_bad++; $display("FAIL scratch_be: got %h want %h", d, 32'hFF34_FF78); end
        bus_write(5'h0F, 32'hA5A5_5A5A, 4'hF);
        bus_read(5'h0F, d);
        n_cmp++; if (d !== 32'hA5A5_5A5A) begin n_bad++; $display("FAIL scratch7: got %h want %h", d, 32'hA5A5_5A5A); end
        bus_write(5'h07, 32'hFFFF_FFFF, 4'hF);
        bus_read(5'h07, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped: got %h want %h", d, 32'h0); end
        bus_write(5'h00, 32'h0, 4'hF);
        bus_read(5'h00, d);
        n_cmp++; if (d !== 32'h4741_4D45) begin n_bad++; $display("FAIL id_ro: got %h want %h", d, 32'h4741_4D45); end
        // Read and write in the same cycle: read sees the old value.
        addr = 5'h09; wdata = 32'h1111_2222; be = 4'hF; wr = 1'b1; rd = 1'b1;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0; be = '0;
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rw_same_cycle: got %h want %h", rdata, 32'h0); end
        bus_read(5'h09, d);
        n_cmp++; if (d !== 32'h1111_2222) begin n_bad++; $display("FAIL rw_after: got %h want %h", d, 32'h1111_2222); end
    endtask

    task automatic test_debounce;
        logic [31:0] d;
        press(2, 5);
        bus_read(5'h02, d);
        n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL short_pulse: got %h want %h", d, 32'h100); end
        btn[2] = 1'b1;
        repeat (20) @(negedge clk);
        bus_read(5'h02, d);
        n_cmp++; if (d !== 32'h0001_0004) begin n_bad++; $display("FAIL held_status: got %h want %h", d, 32'h0001_0004); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_disabled: got %b want 0", irq); end
        bus_read(5'h03, d);
        n_cmp++; if (d !== 32'h0000_0004) begin n_bad++; $display("FAIL event_mask: got %h want %h", d, 32'h4); end
        bus_read(5'h02, d);
        n_cmp++; if (d !== 32'h0000_0104) begin n_bad++; $display("FAIL status_empty: got %h want %h", d, 32'h104); end
        bus_read(5'h03, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL event_empty: got %h want %h", d, 32'h0); end
        btn[2] = 1'b0;
        repeat (20) @(negedge clk);
        bus_read(5'h02, d);
        n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL release: got %h want %h", d, 32'h100); end
    endtask

    task automatic test_tick;
        logic [31:0] d;
        bus_write(5'h04, 32'h3, 4'hF);
        bus_write(5'h01, 32'h1, 4'hF);
        repeat (39) @(negedge clk);
        bus_write(5'h01, 32'h0, 4'hF);
        bus_read(5'h05, d);
        n_cmp++; if (d !== 32'd10) begin n_bad++; $display("FAIL tick_cnt: got %h want %h", d, 32'd10); end
        press(1, 20);
        bus_read(5'h03, d);
        n_cmp++; if (d !== 32'h000A_0002) begin n_bad++; $display("FAIL event_stamp: got %h want %h", d, 32'h000A_0002); end
    endtask

    task automatic test_irq;
        logic [31:0] d;
        bus_write(5'h01, 32'h2, 4'hF);
        press(0, 20);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_set: got %b want 1", irq); end
        bus_read(5'h03, d);
        n_cmp++; if (d !== 32'h000A_0001) begin n_bad++; $display("FAIL irq_event: got %h want %h", d, 32'h000A_0001); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_hold: got %b want 1", irq); end
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear: got %b want 0", irq); end
        bus_write(5'h01, 32'h0, 4'hF);
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        for (int i = 0; i < 5; i++) press(i, 20);
        bus_read(5'h02, d);
        n_cmp++; if (d !== 32'h0004_0600) begin n_bad++; $display("FAIL full_ovf: got %h want %h", d, 32'h0004_0600); end
        bus_write(5'h06, 32'h1, 4'b0010);
        bus_read(5'h02, d);
        n_cmp++; if (d !== 32'h0004_0600) begin n_bad++; $display("FAIL ovfclr_be: got %h want %h", d, 32'h0004_0600); end
        bus_write(5'h06, 32'h1, 4'h1);
        bus_read(5'h02, d);
        n_cmp++; if (d !== 32'h0004_0200) begin n_bad++; $display("FAIL ovf_clear: got %h want %h", d, 32'h0004_0200); end
        // Line the EVENT read up with the push edge (2 sync + 8 debounce + 1).
        btn[0] = 1'b1;
        repeat (10) @(negedge clk);
        bus_read(5'h03, d);
        n_cmp++; if (d !== 32'h000A_0001) begin n_bad++; $display("FAIL pushpop_event: got %h want %h", d, 32'h000A_0001); end
        bus_read(5'h02, d);
        n_cmp++; if (d !== 32'h0004_0201) begin n_bad++; $display("FAIL pushpop_status: got %h want %h", d, 32'h0004_0201); end
        btn[0] = 1'b0;
        repeat (20) @(negedge clk);
        bus_read(5'h03, d);
        n_cmp++; if (d !== 32'h000A_0002) begin n_bad++; $display("FAIL fifo_order: got %h want %h", d, 32'h000A_0002); end
        bus_write(5'h01, 32'h4, 4'h1);
        bus_read(5'h02, d);
        n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL fifo_clear: got %h want %h", d, 32'h100); end
        bus_read(5'h01, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL ctrl_clr_bit: got %h want %h", d, 32'h0); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        bus_write(5'h08, 32'hDEAD_BEEF, 4'hF);
        bus_write(5'h01, 32'h3, 4'hF);
        press(3, 20);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
        bus_read(5'h00, d);
        btn[4] = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL mid_reset_readdata: got %h want %h", rdata, 32'h0); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL mid_reset_irq: got %b want 0", irq); end
        btn[4] = 1'b0;
        reset = 1'b0;
        bus_read(5'h02, d);
        n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL post_reset_status: got %h want %h", d, 32'h100); end
        bus_read(5'h05, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL post_reset_tickcnt: got %h want %h", d, 32'h0); end
        bus_read(5'h04, d);
        n_cmp++; if (d !== 32'h0000_C34F) begin n_bad++; $display("FAIL post_reset_tickdiv: got %h want %h", d, 32'h0000_C34F); end
        bus_read(5'h08, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL post_reset_scratch: got %h want %h", d, 32'h0); end
        bus_read(5'h01, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL post_reset_ctrl: got %h want %h", d, 32'h0); end
        repeat (20) @(negedge clk);
        bus_read(5'h02, d);
        n_cmp++; if (d !== 32'h0000_0100) begin n_bad++; $display("FAIL no_ghost_event: got %h want %h", d, 32'h100); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_scratch();
        test_debounce();
        test_tick();
        test_irq();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
